// File: rtl/axi_bram_pkg.sv
// Shared definitions for the AXI4-Lite block-RAM controller.
//   ctrl_state_e : controller sequencing states
//   RESP_*       : AXI response encodings
//   resp_for()   : maps an address-range error flag to a response code
package axi_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } ctrl_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/bram_rd_latency_ctr.sv
// Read-latency sequencer for the BRAM port.
// Loaded with READ_LATENCY in the cycle the BRAM read is issued, then counts
// down once per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : read is being issued this cycle
//   regce_o    : output-register enable (only when READ_LATENCY = 2)
//   capture_o  : bram_dout holds the read word at the end of this cycle
module bram_rd_latency_ctr
  import axi_bram_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic regce_o,
  output logic capture_o
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(READ_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // First waiting cycle drives the output register; the last one holds valid data.
  assign regce_o   = (READ_LATENCY == 2) && (cnt_q == CW'(READ_LATENCY));
  assign capture_o = (cnt_q == CW'(1));

endmodule

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave driving one port of a byte-write block RAM.
// One transaction in flight at a time; reads and writes share the BRAM port,
// ties between a full write (AW+W) and a read are alternated.
//   clk, rst                 : clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*        : AXI4-Lite write address / data / response channels
//   s_ar*, s_r*              : AXI4-Lite read address / data channels
//   bram_addr/din/we/en      : BRAM port address, write data, byte enables, enable
//   bram_regce, bram_rst     : BRAM output-register enable and reset
//   bram_dout                : BRAM read data
module axi_lite_bram_ctrl
  import axi_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int NB_COL       = 4,
  parameter int RAM_DEPTH    = 131072,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [NB_COL*8-1:0]          s_wdata,
  input  logic [NB_COL-1:0]            s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_WIDTH-1:0]        s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [NB_COL*8-1:0]          s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [$clog2(RAM_DEPTH)-1:0] bram_addr,
  output logic [NB_COL*8-1:0]          bram_din,
  output logic [NB_COL-1:0]            bram_we,
  output logic                         bram_en,
  output logic                         bram_regce,
  output logic                         bram_rst,
  input  logic [NB_COL*8-1:0]          bram_dout
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int OFF_W  = $clog2(NB_COL);
  localparam int DW     = NB_COL * 8;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(RAM_DEPTH) * (ADDR_WIDTH + 1)'(NB_COL);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  ctrl_state_e       state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              err_q, err_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NB_COL-1:0] wstrb_q, wstrb_d;

  logic wr_req, grant_wr, grant_rd;
  logic rd_load, rd_regce, rd_capture;

  assign wr_req   = s_awvalid && s_wvalid;
  // On a tie the type that lost last time wins.
  assign grant_wr = wr_req && (!s_arvalid || !last_wr_q);
  assign grant_rd = s_arvalid && !grant_wr;
  assign rd_load  = (state_q == RD_ISSUE);

  bram_rd_latency_ctr #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_lat (
    .clk      (clk),
    .rst      (rst),
    .load_i   (rd_load),
    .regce_o  (rd_regce),
    .capture_o(rd_capture)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    err_d     = err_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;

    case (state_q)
      IDLE: begin
        // Readies are held low during reset so no handshake can slip through.
        if (!rst) begin
          if (grant_wr) begin
            s_awready = 1'b1;
            s_wready  = 1'b1;
            state_d   = WR_ISSUE;
            last_wr_d = 1'b1;
            addr_d    = s_awaddr[RAM_AW+OFF_W-1:OFF_W];
            err_d     = out_of_range(s_awaddr);
            bresp_d   = resp_for(out_of_range(s_awaddr));
            wdata_d   = s_wdata;
            wstrb_d   = s_wstrb;
          end else if (grant_rd) begin
            s_arready = 1'b1;
            state_d   = RD_ISSUE;
            last_wr_d = 1'b0;
            addr_d    = s_araddr[RAM_AW+OFF_W-1:OFF_W];
            err_d     = out_of_range(s_araddr);
            rresp_d   = resp_for(out_of_range(s_araddr));
          end
        end
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_bready) state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_capture) begin
          rdata_d = err_q ? '0 : bram_dout;
          state_d = RD_RESP;
        end
      end
      RD_RESP:  if (s_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  // Out-of-range transactions keep their timing but never touch the BRAM.
  assign bram_en    = ((state_q == WR_ISSUE) || (state_q == RD_ISSUE)) && !err_q;
  assign bram_we    = ((state_q == WR_ISSUE) && !err_q) ? wstrb_q : '0;
  assign bram_regce = rd_regce && (state_q == RD_WAIT) && !err_q;
  assign bram_addr  = addr_q;
  assign bram_din   = wdata_q;
  assign bram_rst   = rst;

  assign s_bvalid = (state_q == WR_RESP);
  assign s_bresp  = bresp_q;
  assign s_rvalid = (state_q == RD_RESP);
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Self-checking bench for axi_lite_bram_ctrl: a READ_LATENCY=2 instance with a
// behavioural BRAM, plus a READ_LATENCY=1 instance for the low-latency timing.
module tb_axi_lite_bram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- READ_LATENCY = 2 instance ----------------
  logic [31:0] awaddr, wdata, araddr, rdata, bram_din, bram_dout;
  logic [3:0]  wstrb, bram_we;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic        bram_en, bram_regce, bram_rst;
  logic [1:0]  bresp, rresp;
  logic [16:0] bram_addr;

  axi_lite_bram_ctrl #(.ADDR_WIDTH(32), .NB_COL(4), .RAM_DEPTH(131072), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
    .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
    .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en),
    .bram_regce(bram_regce), .bram_rst(bram_rst), .bram_dout(bram_dout)
  );

  // ---------------- READ_LATENCY = 1 instance ----------------
  logic [31:0] d1_awaddr, d1_wdata, d1_araddr, d1_rdata, d1_din, d1_dout;
  logic [3:0]  d1_wstrb, d1_we;
  logic        d1_awvalid, d1_awready, d1_wvalid, d1_wready, d1_bvalid, d1_bready;
  logic        d1_arvalid, d1_arready, d1_rvalid, d1_rready;
  logic        d1_en, d1_regce, d1_brst;
  logic [1:0]  d1_bresp, d1_rresp;
  logic [16:0] d1_addr;

  axi_lite_bram_ctrl #(.ADDR_WIDTH(32), .NB_COL(4), .RAM_DEPTH(131072), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_awaddr(d1_awaddr), .s_awvalid(d1_awvalid), .s_awready(d1_awready),
    .s_wdata(d1_wdata), .s_wstrb(d1_wstrb), .s_wvalid(d1_wvalid), .s_wready(d1_wready),
    .s_bresp(d1_bresp), .s_bvalid(d1_bvalid), .s_bready(d1_bready),
    .s_araddr(d1_araddr), .s_arvalid(d1_arvalid), .s_arready(d1_arready),
    .s_rdata(d1_rdata), .s_rresp(d1_rresp), .s_rvalid(d1_rvalid), .s_rready(d1_rready),
    .bram_addr(d1_addr), .bram_din(d1_din), .bram_we(d1_we), .bram_en(d1_en),
    .bram_regce(d1_regce), .bram_rst(d1_brst), .bram_dout(d1_dout)
  );

  // ---------------- BRAM models ----------------
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  logic [31:0] bmem0 [0:131071];
  logic [31:0] bmem1 [0:131071];
  logic [31:0] rd0_q;
  int          en_cnt = 0;
  logic        d1_regce_seen = 1'b0;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we != 4'h0) bmem0[bram_addr] <= merge(bmem0[bram_addr], bram_din, bram_we);
      else rd0_q <= bmem0[bram_addr];
      en_cnt <= en_cnt + 1;
    end
    if (bram_regce) bram_dout <= rd0_q;
  end

  always @(posedge clk) begin
    if (d1_en) begin
      if (d1_we != 4'h0) bmem1[d1_addr] <= merge(bmem1[d1_addr], d1_din, d1_we);
      else d1_dout <= bmem1[d1_addr];
    end
    if (d1_regce) d1_regce_seen <= 1'b1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int bdly, output logic [1:0] resp, output int lat, output bit ok);
    int k;
    bit hs, got;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    hs = 1'b0; k = 0;
    while (!hs && k < 50) begin @(negedge clk); k++; hs = awready && wready; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0; k = 0;
    while (!got && k < 50) begin @(negedge clk); k++; got = bvalid; end
    lat = k; resp = bresp;
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      if (!bvalid || bram_en) got = 1'b0;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    ok = hs && got;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly, output logic [31:0] d,
                         output logic [1:0] resp, output int lat, output bit ok);
    int k;
    bit hs, got;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    hs = 1'b0; k = 0;
    while (!hs && k < 50) begin @(negedge clk); k++; hs = arready; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    got = 1'b0; k = 0;
    while (!got && k < 50) begin @(negedge clk); k++; got = rvalid; end
    lat = k; d = rdata; resp = rresp;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!rvalid || rdata !== d || bram_en) got = 1'b0;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    ok = hs && got;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] rmem [8];
  logic [31:0] rd_d, ref_d, mask;
  logic [1:0]  resp;
  int          lat, en0, exp_en, k, ng, nw;
  bit          ok, seen, bad, gw, gr, both, inr, w;
  logic [2:0]  seq;
  logic [31:0] a, d;
  logic [3:0]  s;

  initial begin
    tbl[0] = '{1'b1, 32'h20,    32'h11223344, 4'hF, 2'b00, 32'h0};
    tbl[1] = '{1'b1, 32'h20,    32'h0000AB00, 4'h2, 2'b00, 32'h0};
    tbl[2] = '{1'b0, 32'h20,    32'h0,        4'h0, 2'b00, 32'h1122AB44};
    tbl[3] = '{1'b1, 32'h24,    32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    tbl[4] = '{1'b1, 32'h24,    32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
    tbl[5] = '{1'b0, 32'h27,    32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 32'h80000, 32'h0,        4'h0, 2'b10, 32'h0};
    tbl[7] = '{1'b1, 32'h80000, 32'h12345678, 4'hF, 2'b10, 32'h0};
    tbl[8] = '{1'b1, 32'h7FFFC, 32'h0BADF00D, 4'hF, 2'b00, 32'h0};
    tbl[9] = '{1'b0, 32'h7FFFC, 32'h0,        4'h0, 2'b00, 32'h0BADF00D};

    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    bready = 1'b0; rready = 1'b0;
    d1_awaddr = '0; d1_wdata = '0; d1_wstrb = '0; d1_araddr = '0;
    d1_awvalid = 1'b0; d1_wvalid = 1'b0; d1_arvalid = 1'b0; d1_bready = 1'b0; d1_rready = 1'b0;

    // Reset with all request valids high: nothing may be accepted.
    rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_bram_ctl", {bram_en, bram_we, bram_regce}, 6'h0);
    chk("rst_rdata_resp", {rdata, bresp, rresp}, 36'h0);
    chk("rst_bram_rst", bram_rst, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("bram_rst_release", bram_rst, 1'b0);

    // Cycle-accurate write of DEADBEEF to 0x10 followed by a read.
    @(posedge clk); #1;
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("wr_T_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wr_T1_en_we", {bram_en, bram_we}, 5'b11111);
    chk("wr_T1_addr", bram_addr, 17'd4);
    chk("wr_T1_din", bram_din, 32'hDEADBEEF);
    chk("wr_T1_bvalid", bvalid, 1'b0);
    @(negedge clk);
    chk("wr_T2_b", {bvalid, bresp, bram_en}, 4'b1000);
    @(posedge clk); #1;
    bready = 1'b0;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rd_T_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rd_T1_en", {bram_en, bram_we, bram_regce}, 6'b100000);
    chk("rd_T1_addr", bram_addr, 17'd4);
    @(negedge clk);
    chk("rd_T2_regce", {bram_en, bram_regce, rvalid}, 3'b010);
    @(negedge clk);
    chk("rd_T3_rvalid", rvalid, 1'b0);
    @(negedge clk);
    chk("rd_T4_r", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hDEADBEEF});
    @(posedge clk); #1;
    rready = 1'b0;

    // Table-driven transactions.
    en0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, resp, lat, ok);
        chk($sformatf("tbl%0d_wr_ok", i), ok, 1'b1);
        chk($sformatf("tbl%0d_bresp", i), resp, tbl[i].exp_resp);
      end else begin
        do_read(tbl[i].addr, i % 3, rd_d, resp, lat, ok);
        chk($sformatf("tbl%0d_rd_ok", i), ok, 1'b1);
        chk($sformatf("tbl%0d_rresp", i), resp, tbl[i].exp_resp);
        chk($sformatf("tbl%0d_rdata", i), rd_d, tbl[i].exp_rdata);
      end
    end
    chk("tbl_bram_en_count", en_cnt - en0, 8);

    // R held with rready low for 5 cycles while another read waits.
    @(posedge clk); #1;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 50) begin @(negedge clk); k++; seen = arready; end
    chk("hold_ar_hs", seen, 1'b1);
    @(posedge clk); #1;
    araddr = 32'h20;
    seen = 1'b0; k = 0;
    while (!seen && k < 50) begin @(negedge clk); k++; seen = rvalid; end
    chk("hold_rvalid_seen", seen, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (!rvalid || rdata !== 32'hDEADBEEF || arready || bram_en) bad = 1'b1;
    end
    chk("hold_stable", bad, 1'b0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("hold_next_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 50) begin @(negedge clk); k++; seen = rvalid; end
    chk("hold_next_rdata", rdata, 32'h1122AB44);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Arbitration after reset: W and R tie twice -> write, read, write.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    awaddr = 32'h40; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h10; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    ng = 0; nw = 0; seq = '0; both = 1'b0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      @(negedge clk);
      gw = awready && wready;
      gr = arready;
      if (gw && gr) both = 1'b1;
      if (gw) begin seq[ng] = 1'b1; ng++; nw++; end
      else if (gr) begin seq[ng] = 1'b0; ng++; end
      @(posedge clk); #1;
      if (gw) begin
        if (nw == 1) begin awaddr = 32'h44; wdata = 32'h2; end
        else begin awvalid = 1'b0; wvalid = 1'b0; end
      end
      if (gr) arvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("arb_grants", ng, 3);
    chk("arb_order", seq, 3'b101);
    chk("arb_exclusive", both, 1'b0);
    repeat (10) @(posedge clk);
    #1; bready = 1'b0; rready = 1'b0;
    do_read(32'h40, 0, rd_d, resp, lat, ok);
    chk("arb_wr1_data", rd_d, 32'h1);
    do_read(32'h44, 0, rd_d, resp, lat, ok);
    chk("arb_wr2_data", rd_d, 32'h2);

    // Reset while the read is waiting on the BRAM drops it silently.
    @(posedge clk); #1;
    araddr = 32'h24; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rstwait_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rvalid) seen = 1'b1; end
    chk("rstwait_no_rvalid", seen, 1'b0);
    @(posedge clk); #1;
    rready = 1'b0;
    do_read(32'h24, 1, rd_d, resp, lat, ok);
    chk("rstwait_next_ok", ok, 1'b1);
    chk("rstwait_next_data", rd_d, 32'hCAFEF00D);

    // Randomised traffic against a word-array reference model.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      do_write(32'h1000 + 32'(i * 4), d, 4'hF, 0, resp, lat, ok);
      rmem[i] = d;
      chk("rand_prefill_ok", ok, 1'b1);
    end
    en0 = en_cnt; exp_en = 0;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0008_0000;
      else a = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      inr = (a < 32'h0008_0000);
      if (w) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), resp, lat, ok);
        chk("rand_wr_ok", ok, 1'b1);
        chk("rand_wr_lat", lat, 2);
        chk("rand_bresp", resp, inr ? 2'b00 : 2'b10);
        if (inr) begin
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
          rmem[(a - 32'h1000) >> 2] = (rmem[(a - 32'h1000) >> 2] & ~mask) | (d & mask);
          exp_en++;
        end
      end else begin
        do_read(a, $urandom_range(0, 4), rd_d, resp, lat, ok);
        ref_d = inr ? rmem[(a - 32'h1000) >> 2] : 32'h0;
        chk("rand_rd_ok", ok, 1'b1);
        chk("rand_rd_lat", lat, 4);
        chk("rand_rresp", resp, inr ? 2'b00 : 2'b10);
        chk("rand_rdata", rd_d, ref_d);
        if (inr) exp_en++;
      end
    end
    chk("rand_bram_en_count", en_cnt - en0, exp_en);

    // READ_LATENCY = 1 instance: rvalid three cycles after the AR handshake.
    @(posedge clk); #1;
    d1_awaddr = 32'h10; d1_wdata = 32'hDEADBEEF; d1_wstrb = 4'hF;
    d1_awvalid = 1'b1; d1_wvalid = 1'b1; d1_bready = 1'b1;
    @(negedge clk);
    chk("rl1_wr_ready", {d1_awready, d1_wready}, 2'b11);
    @(posedge clk); #1;
    d1_awvalid = 1'b0; d1_wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rl1_bvalid", {d1_bvalid, d1_bresp}, 3'b100);
    @(posedge clk); #1;
    d1_bready = 1'b0;
    d1_araddr = 32'h10; d1_arvalid = 1'b1; d1_rready = 1'b1;
    @(negedge clk);
    chk("rl1_arready", d1_arready, 1'b1);
    @(posedge clk); #1;
    d1_arvalid = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin @(negedge clk); k++; seen = d1_rvalid; end
    chk("rl1_rvalid_lat", k, 3);
    chk("rl1_rdata", d1_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    d1_rready = 1'b0;
    @(negedge clk);
    chk("rl1_no_regce", d1_regce_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
